// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared types, opcodes and helpers for the any1 address-generation path
package any1_pkg;

    typedef logic [31:0] Value;
    typedef logic [31:0] Address;

    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDX  = 8'h10,
        OP_LDXX = 8'h11,
        OP_STX  = 8'h20,
        OP_STXX = 8'h21,
        OP_LEAX = 8'h30
    } opcode_e;

    // func selects the index scale; s enables scaling on indexed loads/stores; ib picks the LEAX index operand
    typedef struct packed {
        opcode_e     opcode;
        logic [2:0]  func;
        logic        s;
        logic [1:0]  ib;
    } Instruction;

    localparam Instruction NOP = '{opcode: OP_NOP, func: 3'd0, s: 1'b0, ib: 2'd0};

    localparam int AR_SRCW = 3;
    localparam int AR_TAGW = 16;

    typedef struct packed {
        Address               ea;
        logic [AR_SRCW-1:0]   src;
        logic [AR_TAGW-1:0]   tag;
    } AgenResult;

    function automatic logic [1:0] scale_amt(input logic [2:0] func);
        return (func > 3'd3) ? 2'd3 : func[1:0];
    endfunction

endpackage

// File: rtl/any1_agen.sv
// rtl/any1_agen.sv - effective-address generator with a registered result
module any1_agen
    import any1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  Instruction  i_ir,
    input  Value        i_a,
    input  Value        i_b,
    input  Value        i_c,
    input  Value        i_imm,
    output Address      o_ea
);

    Address     r_ea;
    Address     w_ea;
    Value       w_idx;
    logic [1:0] w_sh;

    assign w_sh = scale_amt(i_ir.func);

    always_comb begin
        w_idx = '0;
        w_ea  = '0;
        case (i_ir.opcode)
            OP_LDX, OP_STX: begin
                w_ea = i_a + i_imm;
            end
            OP_LDXX, OP_STXX: begin
                w_idx = i_ir.s ? (i_c << w_sh) : i_c;
                w_ea  = i_a + w_idx + i_imm;
            end
            OP_LEAX: begin
                // ib: 0 = no index, 1 = b, 2/3 = c
                case (i_ir.ib)
                    2'd0:    w_idx = '0;
                    2'd1:    w_idx = i_b << w_sh;
                    default: w_idx = i_c << w_sh;
                endcase
                w_ea = i_a + w_idx + i_imm;
            end
            default: w_ea = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_ea <= '0;
        else     r_ea <= w_ea;
    end

    assign o_ea = r_ea;

endmodule

// File: rtl/any1_rr_arb.sv
// rtl/any1_rr_arb.sv - round-robin picker: first set request at or after ptr, wrapping modulo N
module any1_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]          i_req,
    input  logic [$clog2(N)-1:0]  i_ptr,
    output logic [N-1:0]          o_grant,
    output logic [$clog2(N)-1:0]  o_index,
    output logic                  o_any
);

    localparam int IW = $clog2(N);

    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_index    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/any1_agen_arb.sv
// rtl/any1_agen_arb.sv - round-robin arbiter steering NREQ requesters into one agen, results via an output queue
module any1_agen_arb
    import any1_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int TAGW   = 5,
    parameter int QDEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_v,
    output logic [NREQ-1:0]           req_rdy,
    input  Instruction                req_ir  [NREQ],
    input  Value                      req_a   [NREQ],
    input  Value                      req_b   [NREQ],
    input  Value                      req_c   [NREQ],
    input  Value                      req_imm [NREQ],
    input  logic [TAGW-1:0]           req_tag [NREQ],
    input  logic                      flush,
    output logic                      out_v,
    input  logic                      out_rdy,
    output Address                    out_ea,
    output logic [$clog2(NREQ)-1:0]   out_src,
    output logic [TAGW-1:0]           out_tag
);

    localparam int SRCW = $clog2(NREQ);
    localparam int PW   = $clog2(QDEPTH);
    localparam int CW   = PW + 1;
    localparam int OW   = CW + 1;

    logic [SRCW-1:0] r_rr;
    logic            r_s1_v;
    logic [SRCW-1:0] r_s1_src;
    logic [TAGW-1:0] r_s1_tag;
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    Address          r_q_ea  [QDEPTH];
    logic [SRCW-1:0] r_q_src [QDEPTH];
    logic [TAGW-1:0] r_q_tag [QDEPTH];

    logic            w_pop;
    logic [OW-1:0]   w_occ;
    logic            w_elig;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_grant;
    logic [SRCW-1:0] w_idx;
    logic            w_any;
    Instruction      w_ir;
    Value            w_a;
    Value            w_b;
    Value            w_c;
    Value            w_imm;
    Address          w_ea;

    assign out_v  = (r_cnt != '0);
    assign w_pop  = out_v & out_rdy;

    // Occupancy counts the result still in the agen stage so a grant never overruns the queue.
    assign w_occ  = {1'b0, r_cnt} + OW'(r_s1_v) - OW'(w_pop);
    assign w_elig = (w_occ < OW'(QDEPTH));
    assign w_req  = (rst || flush || !w_elig) ? '0 : req_v;

    any1_rr_arb #(.N(NREQ)) u_rr_arb (
        .i_req   (w_req),
        .i_ptr   (r_rr),
        .o_grant (w_grant),
        .o_index (w_idx),
        .o_any   (w_any)
    );

    assign req_rdy = w_grant;

    always_comb begin
        w_ir  = NOP;
        w_a   = '0;
        w_b   = '0;
        w_c   = '0;
        w_imm = '0;
        if (w_any) begin
            w_ir  = req_ir[w_idx];
            w_a   = req_a[w_idx];
            w_b   = req_b[w_idx];
            w_c   = req_c[w_idx];
            w_imm = req_imm[w_idx];
        end
    end

    any1_agen u_agen (
        .clk   (clk),
        .rst   (rst),
        .i_ir  (w_ir),
        .i_a   (w_a),
        .i_b   (w_b),
        .i_c   (w_c),
        .i_imm (w_imm),
        .o_ea  (w_ea)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr     <= '0;
            r_s1_v   <= 1'b0;
            r_s1_src <= '0;
            r_s1_tag <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_s1_v <= 1'b0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
        end else begin
            r_s1_v <= w_any;
            if (w_any) begin
                r_s1_src <= w_idx;
                r_s1_tag <= req_tag[w_idx];
                r_rr     <= (w_idx == SRCW'(NREQ - 1)) ? '0 : w_idx + SRCW'(1);
            end
            if (r_s1_v) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(r_s1_v) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && r_s1_v) begin
            r_q_ea[r_wp]  <= w_ea;
            r_q_src[r_wp] <= r_s1_src;
            r_q_tag[r_wp] <= r_s1_tag;
        end
    end

    assign out_ea  = out_v ? r_q_ea[r_rp]  : '0;
    assign out_src = out_v ? r_q_src[r_rp] : '0;
    assign out_tag = out_v ? r_q_tag[r_rp] : '0;

endmodule

// File: doc/any1_agen_arb.md
# any1_agen_arb

Arbiter and sequencer for the shared address-generation unit. Up to NREQ requesters (load queue, store queue, LEA issue, etc.) present address-generation work. One request is granted per cycle, round-robin, and steered into a single `any1_agen` instance. Each result is returned with its requester ID and tag through a small output queue with downstream backpressure.

## Interface
Parameters:
- NREQ, 4 — number of requesters (2..8)
- TAGW, 5 — width of the requester-supplied tag
- QDEPTH, 2 — output queue entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_v  in  NREQ  per-requester request valid
- req_rdy  out  NREQ  one-hot grant; asserted only where req_v is set
- req_ir  in  NREQ×Instruction  instruction per requester
- req_a, req_b, req_c, req_imm  in  NREQ×Value  operands per requester
- req_tag  in  NREQ×TAGW  opaque tag per requester
- flush  in  1  discard all in-flight and queued results
- out_v  out  1  result valid (queue head)
- out_rdy  in  1  consumer accepts head
- out_ea  out  Address  effective address
- out_src  out  $clog2(NREQ)  granted requester index
- out_tag  out  TAGW  tag of the granted request

## Operation
- Handshake: request i is transferred in any cycle where req_v[i] & req_rdy[i]. Requesters hold req_v and all payload stable until granted. req_rdy may depend combinationally on req_v.
- Eligibility: grant only when `cnt + s1_v - pop < QDEPTH`. Here cnt is queue occupancy, s1_v marks a result in the agen stage, and pop = out_v & out_rdy.
- Round-robin: pointer rr points at the highest-priority index. Search starts at rr and wraps modulo NREQ. After a grant to index g, rr becomes (g+1) mod NREQ. With no grant, rr is unchanged.
- Steering: the granted requester's ir/a/b/c/imm drive the agen combinationally. With no grant, the ir opcode is forced to a non-memory value, so agen produces 0.
- Sideband: grant registers s1_v=1, s1_src=g and s1_tag alongside the agen result register.
- Queue push: when s1_v=1, {ea, s1_src, s1_tag} is pushed in the following cycle. Push and pop may occur in the same cycle. Push when the queue is full cannot happen, because eligibility prevents it.
- Flush: when flush=1, s1_v, the queue pointers and cnt clear at the next edge. rr is retained. No grant is issued in the flush cycle, so req_rdy=0.
- Reset: rr=0, s1_v=0, cnt=0 and queue pointers=0. out_v=0, out_ea=0, out_src=0, out_tag=0. req_rdy=0 during rst.

## Timing
- Grant in cycle N. ea is captured by agen at the end of N, and s1_v=1 during N+1.
- The result is written into the queue at the end of N+1. out_v=1 from N+2 at the earliest (2-cycle latency).
- Throughput: one grant per cycle with out_rdy held high and QDEPTH≥2. With out_rdy low, at most QDEPTH results are outstanding, and grants stop until a pop.
- Simultaneous pop and full queue: a grant is still allowed that cycle.
- Reset or flush mid-operation: in-flight results are lost silently. Requesters that were granted are not re-notified; owning queues replay.
- The queue is a circular buffer with wrap-around read/write pointers of $clog2(QDEPTH) bits. cnt is $clog2(QDEPTH)+1 bits.

## Structure
- any1_pkg supplies Instruction, Value and Address, plus a shared non-memory opcode constant (NOP) used for the idle steer.
- Add AgenResult (ea, src, tag) as a struct to any1_pkg for consumers.
- The round-robin picker is a natural sub-module: any1_rr_arb, with parameter N and inputs req, ptr, outputs grant one-hot and index. It is reusable for other shared units.
- Instantiate any1_agen once, with rst/clk passed through. The queue is inline.

## Test plan
- Single request: req_v=0001, LDx, a=0x1000, imm=0x20, tag=3 at N → req_rdy=0001 at N; out_v at N+2 with ea=0x1020, src=0, tag=3.
- Fairness: all four requesters hold req_v, out_rdy=1 → grants in order 0,1,2,3,0… one per cycle. out_src follows the same order with 2-cycle lag.
- Backpressure: QDEPTH=2, out_rdy=0, continuous requests → exactly 2 grants, then req_rdy=0. Raising out_rdy for 1 cycle → exactly one further grant.
- Indexed: STxX, a=0x100, c=0x4, imm=0, func=3 with S=1 → ea=0x120. LEAX, ib=2, func=7 → shift by 3.
- Flush: two results queued, one in the agen stage, assert flush → out_v=0 next cycle. Next grant is to the index after the last granted; its result appears alone.
- Reset mid-stream: rst high for 1 cycle while busy → all outputs 0 the following cycle. The first grant after reset goes to index 0.
